// File: rtl/flash_op_seq.sv
// Flash operation sequencer: splits a read/program/erase command into single-word
// requests toward the protection stage. Optional request watchdog: FLASH_OP_SEQ_TIMEOUT_EN.
module flash_op_seq #(
  parameter int AW   = 17,
  parameter int DW   = 32,
  parameter int CntW = 12
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            op_start_i,
  input  logic [1:0]      op_type_i,
  input  logic            op_erase_sel_i,
  input  logic [AW-1:0]   op_addr_i,
  input  logic [CntW-1:0] op_num_i,
  output logic            op_busy_o,
  output logic            op_done_o,
  output logic            op_err_o,
  input  logic [DW-1:0]   prog_data_i,
  input  logic            prog_valid_i,
  output logic            prog_ready_o,
  output logic [DW-1:0]   rd_data_o,
  output logic            rd_valid_o,
  input  logic            rd_ready_i,
  output logic            flash_req_o,
  output logic            flash_rd_o,
  output logic            flash_prog_o,
  output logic            flash_pg_erase_o,
  output logic            flash_bk_erase_o,
  output logic [AW-1:0]   flash_addr_o,
  output logic            flash_ovfl_o,
  output logic [DW-1:0]   flash_prog_data_o,
  input  logic            flash_rd_done_i,
  input  logic            flash_prog_done_i,
  input  logic            flash_erase_done_i,
  input  logic            flash_error_i,
  input  logic [DW-1:0]   flash_rd_data_i
);

  localparam logic [1:0] OP_RD    = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    ISSUE    = 3'd2,
    PUSH_RD  = 3'd3,
    FINISH   = 3'd4
  } state_e;

  state_e          state_q;
  logic [1:0]      type_q;
  logic            esel_q;
  logic [AW-1:0]   addr_q;
  logic [CntW-1:0] num_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            ovfl_q;
  logic            busy_q;
  logic            done_q;
  logic            operr_q;
  logic            req_q;
  logic            rdv_q;
  logic [DW-1:0]   rd_data_q;
  logic [DW-1:0]   prog_data_q;
  logic            done_match;
  logic            last_word;
  logic [AW:0]     addr_sum_d;
  logic [CntW-1:0] cnt_inc_d;
`ifdef FLASH_OP_SEQ_TIMEOUT_EN
  logic [15:0]     tmo_q;
`endif

  // Only the done pulse of the operation in flight is honoured
  always_comb begin
    done_match = 1'b0;
    case (type_q)
      OP_RD:    done_match = flash_rd_done_i;
      OP_PROG:  done_match = flash_prog_done_i;
      OP_ERASE: done_match = flash_erase_done_i;
      default:  done_match = 1'b0;
    endcase
  end

  assign addr_sum_d = {1'b0, addr_q} + {{AW{1'b0}}, 1'b1};
  assign cnt_inc_d  = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
  assign last_word  = (cnt_q == num_q);

  // Sequencer FSM with all control outputs registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      type_q      <= 2'd0;
      esel_q      <= 1'b0;
      addr_q      <= {AW{1'b0}};
      num_q       <= {CntW{1'b0}};
      cnt_q       <= {CntW{1'b0}};
      err_q       <= 1'b0;
      ovfl_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      operr_q     <= 1'b0;
      req_q       <= 1'b0;
      rdv_q       <= 1'b0;
      rd_data_q   <= {DW{1'b0}};
      prog_data_q <= {DW{1'b0}};
`ifdef FLASH_OP_SEQ_TIMEOUT_EN
      tmo_q       <= 16'd0;
`endif
    end else begin
`ifdef FLASH_OP_SEQ_TIMEOUT_EN
      tmo_q <= 16'd0;
`endif
      case (state_q)
        IDLE: begin
          ovfl_q  <= 1'b0;
          done_q  <= 1'b0;
          operr_q <= 1'b0;
          if (op_start_i) begin
            type_q <= op_type_i;
            esel_q <= op_erase_sel_i;
            addr_q <= op_addr_i;
            num_q  <= op_num_i;
            cnt_q  <= {CntW{1'b0}};
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            case (op_type_i)
              OP_RD, OP_ERASE: begin
                req_q   <= 1'b1;
                state_q <= ISSUE;
              end
              OP_PROG: state_q <= GET_DATA;
              default: begin
                err_q   <= 1'b1;
                state_q <= FINISH;
              end
            endcase
          end
        end
        GET_DATA: begin
          if (prog_valid_i) begin
            prog_data_q <= prog_data_i;
            req_q       <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Completion pulses are raised on entry to FINISH to save a cycle of latency
          if (done_match) begin
            req_q <= 1'b0;
            if (flash_error_i) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              operr_q <= 1'b1;
              state_q <= FINISH;
            end else begin
              case (type_q)
                OP_RD: begin
                  rd_data_q <= flash_rd_data_i;
                  rdv_q     <= 1'b1;
                  state_q   <= PUSH_RD;
                end
                OP_PROG: begin
                  if (last_word) begin
                    done_q  <= 1'b1;
                    state_q <= FINISH;
                  end else begin
                    addr_q  <= addr_sum_d[AW-1:0];
                    cnt_q   <= cnt_inc_d;
                    ovfl_q  <= ovfl_q | addr_sum_d[AW];
                    state_q <= GET_DATA;
                  end
                end
                default: begin
                  done_q  <= 1'b1;
                  state_q <= FINISH;
                end
              endcase
            end
          end else begin
`ifdef FLASH_OP_SEQ_TIMEOUT_EN
            if (tmo_q == 16'hFFFE) begin
              req_q   <= 1'b0;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              operr_q <= 1'b1;
              state_q <= FINISH;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
`else
            req_q <= 1'b1;
`endif
          end
        end
        PUSH_RD: begin
          if (rd_ready_i) begin
            rdv_q <= 1'b0;
            if (last_word) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              addr_q  <= addr_sum_d[AW-1:0];
              cnt_q   <= cnt_inc_d;
              ovfl_q  <= ovfl_q | addr_sum_d[AW];
              req_q   <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        FINISH: begin
          // Illegal commands arrive without a pending pulse and spend one extra cycle here
          if (!done_q) begin
            done_q  <= 1'b1;
            operr_q <= err_q;
          end else begin
            done_q  <= 1'b0;
            operr_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_busy_o         = busy_q;
  assign op_done_o         = done_q;
  assign op_err_o          = operr_q;
  assign prog_ready_o      = (state_q == GET_DATA) && prog_valid_i;
  assign rd_data_o         = rd_data_q;
  assign rd_valid_o        = rdv_q;
  assign flash_req_o       = req_q;
  assign flash_rd_o        = req_q && (type_q == OP_RD);
  assign flash_prog_o      = req_q && (type_q == OP_PROG);
  assign flash_pg_erase_o  = req_q && (type_q == OP_ERASE) && !esel_q;
  assign flash_bk_erase_o  = req_q && (type_q == OP_ERASE) && esel_q;
  assign flash_addr_o      = addr_q;
  assign flash_ovfl_o      = ovfl_q;
  assign flash_prog_data_o = prog_data_q;

endmodule

// File: tb/tb_flash_op_seq.sv
// Randomized self-checking bench for flash_op_seq with a transaction-level reference model.
module tb_flash_op_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        op_start_i = 1'b0;
  logic [1:0]  op_type_i = 2'd0;
  logic        op_erase_sel_i = 1'b0;
  logic [16:0] op_addr_i = 17'd0;
  logic [11:0] op_num_i = 12'd0;
  logic        op_busy_o, op_done_o, op_err_o;
  logic [31:0] prog_data_i = 32'd0;
  logic        prog_valid_i = 1'b0;
  logic        prog_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic        flash_req_o, flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o;
  logic [16:0] flash_addr_o;
  logic        flash_ovfl_o;
  logic [31:0] flash_prog_data_o;
  logic        flash_rd_done_i = 1'b0, flash_prog_done_i = 1'b0, flash_erase_done_i = 1'b0;
  logic        flash_error_i = 1'b0;
  logic [31:0] flash_rd_data_i = 32'd0;

  int errors = 0;
  int checks = 0;

  flash_op_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .op_start_i(op_start_i), .op_type_i(op_type_i), .op_erase_sel_i(op_erase_sel_i),
    .op_addr_i(op_addr_i), .op_num_i(op_num_i),
    .op_busy_o(op_busy_o), .op_done_o(op_done_o), .op_err_o(op_err_o),
    .prog_data_i(prog_data_i), .prog_valid_i(prog_valid_i), .prog_ready_o(prog_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .flash_req_o(flash_req_o), .flash_rd_o(flash_rd_o), .flash_prog_o(flash_prog_o),
    .flash_pg_erase_o(flash_pg_erase_o), .flash_bk_erase_o(flash_bk_erase_o),
    .flash_addr_o(flash_addr_o), .flash_ovfl_o(flash_ovfl_o),
    .flash_prog_data_o(flash_prog_data_o),
    .flash_rd_done_i(flash_rd_done_i), .flash_prog_done_i(flash_prog_done_i),
    .flash_erase_done_i(flash_erase_done_i), .flash_error_i(flash_error_i),
    .flash_rd_data_i(flash_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {op_busy_o, op_done_o, op_err_o, prog_ready_o, rd_valid_o, flash_req_o,
                         flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o, flash_ovfl_o},
          64'd0);
    check({tag, "_addr"}, flash_addr_o, 64'd0);
    check({tag, "_data"}, {rd_data_o, flash_prog_data_o}, 64'd0);
  endtask

  // One command end to end; the model derives every expected request and beat from the command
  task automatic run_cmd(input logic [1:0] typ, input logic esel, input logic [16:0] addr,
                         input logic [11:0] num, input int err_idx, input int fixed_dly,
                         input int prog_hold, input bit rd_all);
    int n_words, n_req, beats_exp;
    bit exp_err, exp_done, fin, in_req, done_sent, err_now;
    int req_seen, pops, beats, dly, done_cd, cyc;
    logic [17:0] full;
    logic [16:0] exp_a;
    logic [31:0] pdata[$];
    logic [31:0] rdq[$];
    logic [31:0] d;

    n_words   = (typ == 2'd2) ? 1 : ((typ == 2'd3) ? 0 : int'(num) + 1);
    exp_err   = (typ == 2'd3) || (err_idx >= 0 && err_idx < n_words);
    n_req     = (err_idx >= 0 && err_idx < n_words) ? err_idx + 1 : n_words;
    beats_exp = (typ != 2'd0) ? 0 : (exp_err ? err_idx : n_words);
    req_seen = 0; pops = 0; beats = 0; dly = 0; done_cd = 0; cyc = 0;
    fin = 1'b0; in_req = 1'b0; done_sent = 1'b0; exp_a = 17'd0;

    @(negedge clk_i);
    op_start_i = 1'b1; op_type_i = typ; op_erase_sel_i = esel; op_addr_i = addr; op_num_i = num;
    if (typ == 2'd3) done_cd = 2;

    while (!fin && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      exp_done = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) exp_done = 1'b1;
      end
      if (exp_done || op_done_o) begin
        check("op_done", op_done_o, exp_done);
        check("op_err", op_err_o, exp_done ? exp_err : 1'b0);
        if (exp_done) fin = 1'b1;
      end
      if (cyc == 1) check("busy_on", op_busy_o, 1'b1);

      // A start while busy must be ignored
      op_start_i = (cyc > 1) && ($urandom_range(0, 5) == 0);
      op_type_i = 2'($urandom_range(0, 3));
      op_addr_i = 17'($urandom);
      op_num_i = 12'($urandom_range(0, 3));
      flash_rd_done_i = 1'b0; flash_prog_done_i = 1'b0; flash_erase_done_i = 1'b0;
      flash_error_i = 1'b0;

      if (done_sent) begin
        check("req_drop", flash_req_o, 1'b0);
        done_sent = 1'b0;
        in_req = 1'b0;
      end else if (flash_req_o) begin
        if (!in_req) begin
          full  = {1'b0, addr} + 18'(req_seen);
          exp_a = full[16:0];
          check("req_addr", flash_addr_o, exp_a);
          check("req_ovfl", flash_ovfl_o, full[17]);
          check("q_rd", flash_rd_o, typ == 2'd0);
          check("q_prog", flash_prog_o, typ == 2'd1);
          check("q_pg_erase", flash_pg_erase_o, typ == 2'd2 && !esel);
          check("q_bk_erase", flash_bk_erase_o, typ == 2'd2 && esel);
          if (typ == 2'd1) begin
            check("prog_gate", pops > req_seen, 1'b1);
            if (pops > req_seen) check("prog_data", flash_prog_data_o, pdata[req_seen]);
          end
          if (req_seen == 0 && typ != 2'd1) check("req_lat", cyc, 1);
          req_seen++;
          in_req = 1'b1;
          dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        end else begin
          check("req_hold", flash_addr_o, exp_a);
        end
        if (dly == 0) begin
          err_now = (req_seen - 1 == err_idx);
          flash_error_i = err_now;
          d = $urandom;
          flash_rd_data_i = d;
          case (typ)
            2'd0:    flash_rd_done_i = 1'b1;
            2'd1:    flash_prog_done_i = 1'b1;
            default: flash_erase_done_i = 1'b1;
          endcase
          if (typ == 2'd0 && !err_now) rdq.push_back(d);
          if (req_seen == n_req && (typ != 2'd0 || err_now)) done_cd = 1;
          done_sent = 1'b1;
        end else begin
          dly--;
          if ($urandom_range(0, 2) == 0) begin
            flash_error_i = 1'b1;
            case (typ)
              2'd0:    flash_prog_done_i = 1'b1;
              2'd1:    flash_erase_done_i = 1'b1;
              default: flash_rd_done_i = 1'b1;
            endcase
          end
        end
      end

      prog_valid_i = (typ == 2'd1) && (cyc > prog_hold) && ($urandom_range(0, 1) == 1);
      prog_data_i  = $urandom;
      rd_ready_i   = rd_all || ($urandom_range(0, 2) != 0);
      #1;
      if (prog_ready_o) begin
        pdata.push_back(prog_data_i);
        pops++;
      end
      if (rd_valid_o && rd_ready_i) begin
        if (rdq.size() == 0) check("rd_extra", 1'b1, 1'b0);
        else check("rd_data", rd_data_o, rdq.pop_front());
        beats++;
        if (typ == 2'd0 && beats == n_words) done_cd = 1;
      end
    end
    op_start_i = 1'b0;
    prog_valid_i = 1'b0;
    flash_rd_done_i = 1'b0; flash_prog_done_i = 1'b0; flash_erase_done_i = 1'b0;
    flash_error_i = 1'b0;
    if (!fin) check("cmd_timeout", 1'b0, 1'b1);
    check("req_count", req_seen, n_req);
    check("rd_beats", beats, beats_exp);
    if (typ == 2'd1) check("prog_pops", pops, n_req);
    @(negedge clk_i);
    check("busy_off", op_busy_o, 1'b0);
    check("idle_req", flash_req_o, 1'b0);
  endtask

  initial begin
    int bound;
    logic [1:0]  t;
    logic [16:0] a;
    logic [11:0] n;
    int r, e;

    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_cmd(2'd0, 1'b0, 17'h00100, 12'd3, -1, 2, 0, 1'b1);
    run_cmd(2'd1, 1'b0, 17'h02345, 12'd1, -1, -1, 5, 1'b0);
    run_cmd(2'd2, 1'b1, 17'h10000, 12'd7, -1, -1, 0, 1'b0);
    run_cmd(2'd0, 1'b0, 17'h00200, 12'd4, 1, -1, 0, 1'b0);
    run_cmd(2'd1, 1'b0, 17'h1FFFF, 12'd1, -1, -1, 0, 1'b0);
    run_cmd(2'd3, 1'b0, 17'h00050, 12'd2, -1, -1, 0, 1'b0);
    run_cmd(2'd2, 1'b0, 17'h0ABCD, 12'd0, 0, -1, 0, 1'b0);
    run_cmd(2'd0, 1'b0, 17'h1FFFE, 12'd3, -1, -1, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 9));
      t = (r < 4) ? 2'd0 : ((r < 7) ? 2'd1 : ((r < 9) ? 2'd2 : 2'd3));
      a = ($urandom_range(0, 3) == 0) ? 17'(17'h1FFFF - 17'($urandom_range(0, 3))) : 17'($urandom);
      n = 12'($urandom_range(0, 5));
      e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(n))) : -1;
      run_cmd(t, 1'($urandom), a, n, e, -1, int'($urandom_range(0, 3)), 1'b0);
    end

    // Asynchronous reset while a request is outstanding
    @(negedge clk_i);
    op_start_i = 1'b1; op_type_i = 2'd0; op_addr_i = 17'h00777; op_num_i = 12'd2;
    @(negedge clk_i);
    op_start_i = 1'b0;
    bound = 0;
    while (!flash_req_o && bound < 20) begin
      @(negedge clk_i);
      bound++;
    end
    check("rst_req_seen", flash_req_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk_i);
    flash_rd_done_i = 1'b1;
    @(negedge clk_i);
    flash_rd_done_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_all_zero("rst_after");
    run_cmd(2'd0, 1'b0, 17'h00010, 12'd1, -1, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_op_seq.md
Name: flash_op_seq

Overview:
- Flash operation sequencer between the software command registers/FIFOs and the flash memory-protection stage.
- Accepts one read, program or erase command: start word address plus word count.
- Splits the command into single-word (or single-erase) requests, handshakes each with the protection/phy done pulses, and moves data through the prog/read FIFO interfaces.
- Aborts the command on the first protection error.

Parameters:
- AW, 17, flash word address width (bank + page + word index).
- DW, 32, flash data width.
- CntW, 12, width of the word-count field (count encoded as N-1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- op_start_i  in  1  start pulse; sampled only in IDLE.
- op_type_i  in  2  0 read, 1 program, 2 erase, 3 illegal.
- op_erase_sel_i  in  1  0 page erase, 1 bank erase.
- op_addr_i  in  AW  start word address.
- op_num_i  in  CntW  number of words minus 1.
- op_busy_o  out  1  command in progress.
- op_done_o  out  1  one-cycle completion pulse.
- op_err_o  out  1  one-cycle error pulse, coincident with op_done_o.
- prog_data_i  in  DW  program data from FIFO.
- prog_valid_i  in  1  program data valid.
- prog_ready_o  out  1  program data pop.
- rd_data_o  out  DW  read data to FIFO.
- rd_valid_o  out  1  read data valid.
- rd_ready_i  in  1  read FIFO has space.
- flash_req_o  out  1  request to protection stage.
- flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o  out  1 each  operation qualifiers.
- flash_addr_o  out  AW  current word address.
- flash_ovfl_o  out  1  address wrapped past 2^AW-1.
- flash_prog_data_o  out  DW  latched program word.
- flash_rd_done_i, flash_prog_done_i, flash_erase_done_i  in  1 each  completion pulses.
- flash_error_i  in  1  protection error; valid with a done pulse.
- flash_rd_data_i  in  DW  read data, valid with flash_rd_done_i.

Behaviour:
- Reset values: all outputs 0; internal address and count 0; FSM in IDLE.
- FSM states: IDLE, GET_DATA, ISSUE, PUSH_RD, FINISH.

IDLE
- op_start_i=1 latches type, erase_sel, addr and num; op_busy_o goes to 1 next cycle.
- Next state: read/erase -> ISSUE; program -> GET_DATA; type 3 -> FINISH with error flag set and no flash request.
- op_start_i is ignored while busy.

GET_DATA
- prog_ready_o = prog_valid_i.
- On transfer: latch prog_data_i into flash_prog_data_o and go to ISSUE.
- Waits indefinitely; no request is issued without data.

ISSUE
- flash_req_o=1 with exactly one qualifier set. Erase uses pg_erase or bk_erase per erase_sel.
- All request outputs are held stable until the matching done pulse. A done pulse for a different operation type is ignored.
- On done with flash_error_i=1: go to FINISH with error flag set. Remaining words are abandoned; no read data is pushed.
- On done without error:
  - Read: capture flash_rd_data_i and go to PUSH_RD.
  - Program: if count==num go to FINISH, else increment address and count and go to GET_DATA.
  - Erase: always a single transaction, go to FINISH; num is ignored.
- flash_req_o drops in the cycle after done; there is a minimum one idle cycle between requests.

PUSH_RD
- rd_valid_o=1 with rd_data_o held until rd_ready_i.
- On accept: if last word go to FINISH, else increment address and count and go to ISSUE.

FINISH
- Pulse op_done_o; pulse op_err_o if the error flag is set. op_busy_o=0 next cycle. Return to IDLE.

Address and count rules
- The address increments modulo 2^AW.
- flash_ovfl_o is set sticky for the rest of the command once a wrap occurs. It is cleared in IDLE.
- A wrapped request is still issued; the protection stage returns the error.
- The count compare uses the full CntW width. num=2^CntW-1 yields 2^CntW words.

Latency
- Read/erase: op_start_i at cycle 0 -> flash_req_o at cycle 1.
- Final done (read: final rd_ready_i accept) at cycle t -> op_done_o at t+1.

Reset mid-operation: asynchronous return to IDLE, all outputs 0; the in-flight done pulse is dropped.

Optional Feature:
- Macro: FLASH_OP_SEQ_TIMEOUT_EN.
- Defined: a 16-bit counter runs while in ISSUE. If 65535 cycles elapse without a done pulse, drop flash_req_o and go to FINISH with op_err_o=1.
- Undefined: no counter; ISSUE waits indefinitely.

Test Plan:
- Read addr=0x00100, num=3, rd_ready_i=1, done 2 cycles after each req -> 4 reqs at addresses 0x100..0x103; 4 rd_valid_o beats with data matching; single op_done_o, op_err_o=0.
- Program num=1, prog_valid_i delayed 5 cycles -> no flash_req_o before data; prog_ready_o pulses exactly twice; flash_prog_data_o matches each word.
- Bank erase addr=0x10000, num=7 -> exactly one req with flash_bk_erase_o=1; op_done_o one cycle after flash_erase_done_i.
- Read num=4 with flash_error_i on 2nd done -> 2 reqs total; rd_valid_o only for word 0; op_done_o and op_err_o pulse together.
- Program addr=0x1FFFF, num=1 -> 2nd req at addr 0x00000 with flash_ovfl_o=1.
- Type 3 start -> op_done_o and op_err_o at cycle 2, flash_req_o never asserted; rst_ni low mid-ISSUE -> all outputs 0 immediately.
